// File: rtl/add_seq_ctrl.sv
`timescale 1ns/1ps
// add_seq_ctrl: nibble-serial adder, one 4-bit ripple slice reused per nibble.
// Ports: clk, rst; start/a/b/cin in; ready/busy/done, sum/cout/ovf out.
module add_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   a_r_q, a_r_d;
  logic [W-1:0]   b_r_q, b_r_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;

  logic [3:0]     sl_a, sl_b, sl_s;
  logic [4:0]     sl_c;

  // The single shared 4-bit ripple slice.
  always_comb begin
    sl_a    = a_r_q[{idx_q, 2'b00} +: 4];
    sl_b    = b_r_q[{idx_q, 2'b00} +: 4];
    sl_s    = '0;
    sl_c    = '0;
    sl_c[0] = carry_q;
    for (int i = 0; i < 4; i++) begin
      sl_s[i]   = sl_a[i] ^ sl_b[i] ^ sl_c[i];
      sl_c[i+1] = (sl_a[i] & sl_b[i]) |
                  (sl_a[i] & sl_c[i]) |
                  (sl_b[i] & sl_c[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_r_d   = a_r_q;
    b_r_d   = b_r_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_r_d   = a;
          b_r_d   = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = sl_s;
        carry_d = sl_c[4];
        if (idx_q == LAST) begin
          cout_d  = sl_c[4];
          // signed overflow: carry into bit 3 vs out of it
          ovf_d   = sl_c[3] ^ sl_c[4];
          // park at 0 so idx stays in range for any NIBBLES
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_r_q   <= '0;
      b_r_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_r_q   <= a_r_d;
      b_r_q   <= b_r_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule
